// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with grant locking and back-to-back handover.
// Define RR_ARB_HOLD_LIMIT_EN to force a release after MAX_HOLD cycles of ownership.
//
// state | meaning
// IDLE  | no owner, grant all-zero, grant_id holds the last owner
// OWNED | one requester holds a one-hot grant until it releases
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_i,
    input  logic           done_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_id_o,
    output logic           grant_valid_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    if ((N < 2) || (N > 32) || (MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_param_check
        $error("rr_arbiter_n: N must be 2..32 and MAX_HOLD 1..255");
    end

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic           gv_q, gv_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           take;
    logic [IDW-1:0] win;
    logic           owner_req;
    logic           release_ev;
    logic           hold_hit;
    logic [N-1:0]   others;

    // First set bit of r searching upward from p+1 and wrapping, so p is checked last.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic [IDW-1:0] i;
        logic           found;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            i = IDW'((int'(p) + k) % N);
            if (!found && r[i]) begin
                w     = i;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

`ifdef RR_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_q, hold_d;

    assign hold_hit = (hold_q == 8'(MAX_HOLD));

    always_comb begin
        hold_d = hold_q;
        if (take) begin
            hold_d = 8'd1;
        end else if (state_q == S_OWNED) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    assign owner_req  = req_i[id_q];
    assign release_ev = !owner_req || done_i || hold_hit;
    assign others     = req_i & ~grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        gv_d    = gv_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        win     = ptr_q;

        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    take = 1'b1;
                    win  = rr_pick(req_i, ptr_q);
                end
            end
            S_OWNED: begin
                if (release_ev) begin
                    // ptr equals the owner here, so the owner is searched last anyway;
                    // masking it makes a forced release hand over whenever anyone else waits.
                    if (|others) begin
                        take = 1'b1;
                        win  = rr_pick(others, id_q);
                    end else if (owner_req) begin
                        take = 1'b1;
                        win  = id_q;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        gv_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                gv_d    = 1'b0;
            end
        endcase

        if (take) begin
            state_d = S_OWNED;
            grant_d = to_onehot(win);
            id_d    = win;
            gv_d    = 1'b1;
            ptr_d   = win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            gv_q    <= 1'b0;
            ptr_q   <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            gv_q    <= gv_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = id_q;
    assign grant_valid_o = gv_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n (N=4, MAX_HOLD=4): directed scenarios
// plus randomized traffic against a behavioural ownership model.
module tb_rr_arbiter_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = $clog2(N);
`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN  = 1'b1;
`else
    localparam bit HOLD_EN  = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    int n_tests;
    int n_fail;

    // Model: owner index (-1 when idle), last winner, last reported id, cycles owned.
    int m_owner;
    int m_ptr;
    int m_id;
    int m_hold;

    rr_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .done_i        (done),
        .grant_o       (grant),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_in_order(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_id    = 0;
        m_hold  = 0;
    endtask

    task automatic model_cycle(input logic [N-1:0] r, input logic d);
        int  w;
        bit  rel;
        w = -1;
        if (m_owner < 0) begin
            if (r != '0) w = next_in_order(r, m_ptr, -1);
        end else begin
            rel = !r[m_owner] || d || (HOLD_EN && m_hold == MAX_HOLD);
            if (rel) begin
                w = next_in_order(r, m_owner, m_owner);
                if (w < 0 && r[m_owner]) w = m_owner;
                if (w < 0) m_owner = -1;
            end else begin
                m_hold++;
            end
        end
        if (w >= 0) begin
            m_owner = w;
            m_ptr   = w;
            m_id    = w;
            m_hold  = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".id"},    32'(grant_id), 32'(m_id));
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input logic [N-1:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        model_cycle(r, d);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input logic [N-1:0] r_after);
        rst = 1'b1;
        #2;
        model_reset();
        check("rst.grant", 32'(grant), 32'h0);
        check("rst.valid", 32'(grant_valid), 32'h0);
        check("rst.id",    32'(grant_id), 32'h0);
        req  = r_after;
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] seq_exp [5];
        logic [N-1:0] r;
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        #12;
        do_reset('0);

        // All requesting, done every cycle: strict rotation with no gaps.
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;
        step(4'b1111, 1'b0, "rot0");
        check("rot.g0", 32'(grant), 32'(seq_exp[0]));
        for (int i = 1; i < 5; i++) begin
            step(4'b1111, 1'b1, "rot");
            check("rot.seq", 32'(grant), 32'(seq_exp[i]));
        end

        // Single requester, then drop to idle.
        do_reset('0);
        step(4'b0100, 1'b0, "single");
        check("single.g", 32'(grant), 32'h4);
        check("single.id", 32'(grant_id), 32'h2);
        step(4'b0100, 1'b0, "single");
        step(4'b0100, 1'b0, "single");
        step(4'b0000, 1'b0, "single.drop");
        check("single.off", 32'(grant_valid), 32'h0);

        // New requesters mid-grant wait; owner drop hands to index 1, not 3.
        do_reset('0);
        step(4'b0001, 1'b0, "skip");
        step(4'b1011, 1'b0, "skip.hold");
        check("skip.hold", 32'(grant), 32'h1);
        step(4'b1010, 1'b0, "skip.drop");
        check("skip.next", 32'(grant), 32'h2);

        // Hold limit behaviour depends on the build.
        do_reset('0);
        for (int i = 0; i < 4; i++) step(4'b0011, 1'b0, "hold.a");
        check("hold.a", 32'(grant), 32'h1);
        step(4'b0011, 1'b0, "hold.b");
`ifdef RR_ARB_HOLD_LIMIT_EN
        check("hold.swap", 32'(grant), 32'h2);
`else
        check("hold.keep", 32'(grant), 32'h1);
`endif
        for (int i = 0; i < 8; i++) step(4'b0011, 1'b0, "hold.run");

        // Single requester under the hold limit gets re-granted.
        do_reset('0);
        for (int i = 0; i < 10; i++) step(4'b1000, 1'b0, "regrant");
        check("regrant.g", 32'(grant), 32'h8);

        // Async reset with grant at index 3, then fresh priority from index 0.
        do_reset('0);
        step(4'b1000, 1'b0, "mid.setup");
        check("mid.setup", 32'(grant), 32'h8);
        #1;
        do_reset(4'b1001);
        step(4'b1001, 1'b0, "mid.after");
        check("mid.first", 32'(grant), 32'h1);

        // done while idle does nothing.
        do_reset('0);
        step(4'b0000, 1'b1, "idle.done");
        step(4'b0000, 1'b1, "idle.done");
        check("idle.g", 32'(grant), 32'h0);
        step(4'b0010, 1'b0, "idle.after");

        // Randomized traffic with sticky requests and sporadic done.
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            else if ($urandom_range(0, 2) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            step(r, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-way round-robin arbiter with grant locking. It sits in front of a shared resource such as a bus port or memory channel. It accepts N request lines and issues a registered one-hot grant. The owner keeps the grant until it releases, and the next grant rotates fairly starting after the last owner. It replaces fixed 3-requester arbitration and adds back-to-back handover, explicit release and an optional hold-time limit.

## Interface
- N, default 4: number of requesters; legal range 2..32.
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant. Used only when RR_ARB_HOLD_LIMIT_EN is defined; legal range 1..255.
- IDW, derived, equal to $clog2(N): width of grant_id.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  request per requester; level-sensitive.
- done  in  1  release pulse from the current owner; ignored when grant_valid=0.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_id  out  IDW  binary index of the owner; holds the last owner when idle.
- grant_valid  out  1  high while any grant bit is set.

## Operation
- State machine: IDLE, OWNED.
- IDLE:
  - No req bits set: stay in IDLE; grant=0, grant_valid=0.
  - Any req bit set: select a winner by rotating priority and go to OWNED.
- Rotating priority: search starts at index ptr+1 mod N and wraps, so index ptr is checked last. ptr is the index of the last winner.
- On every new grant, ptr <= winner.
- OWNED: the owner keeps the grant while req[owner]=1 and done=0.
- Release condition: req[owner]=0, or done=1, or (with macro) the hold limit is reached.
- On release:
  - Any other req bit set: hand over directly to the next winner. The search runs with the owner excluded and ptr = owner. No idle cycle is inserted; state stays OWNED.
  - Only the owner still requests: after a done or hold-limit release, the owner is re-granted. After a req-drop release this case cannot arise.
  - No requests: go to IDLE; grant clears.
- Simultaneous req drop and done count as one release event.
- A req rising on a non-owner while OWNED has no effect until the next release.
- Reset values: state=IDLE, ptr=N-1 (so req[0] has highest priority first), grant=0, grant_id=0, grant_valid=0, hold counter=0.
- Reset mid-grant clears all outputs immediately, asynchronously.

## Timing
- Latency: req sampled at edge k produces a grant visible after edge k, i.e. in cycle k+1.
- Release sampled at edge k: the new grant, or zero, is visible in cycle k+1.
- Handover is back-to-back: grant changes directly from one one-hot value to another with no zero cycle in between.
- grant, grant_id and grant_valid are all flops. No combinational path exists from req or done to any output.
- grant is always one-hot or zero. grant_valid == |grant at all times.

## Configuration
- RR_ARB_HOLD_LIMIT_EN defined:
  - An 8-bit hold counter resets to 1 on each new grant, including a re-grant, and increments each OWNED cycle.
  - When the counter equals MAX_HOLD and the owner still requests, release is forced. The next winner is chosen excluding the owner. If no other requester is present, the owner is re-granted and the counter restarts.
- Not defined:
  - No counter is built and MAX_HOLD is ignored.
  - The owner holds the grant indefinitely until req drop or done.

## Test plan
(N=4, MAX_HOLD=4)
- Reset, then req=4'b1111 held, release by done each cycle → grant sequence 0001, 0010, 0100, 1000, 0001, changing every cycle with no zero cycles.
- req=4'b0100 for 3 cycles then 0 → grant=0100 and grant_id=2 one cycle after req rises. grant=0 and grant_valid=0 one cycle after req falls.
- Owner 0 holds while req changes to 4'b1011 mid-grant, then req[0] drops → grant moves to 0010 (index 1), skipping 1000.
- Macro on: req=4'b0011 held, no done → grant=0001 for exactly 4 cycles, then 0010 for 4 cycles, then 0001. Macro off: grant stays 0001 indefinitely.
- rst asserted mid-grant with grant=1000 → grant=0, grant_valid=0 and grant_id=0 immediately. After rst deasserts with req=4'b1001, the first grant is 0001.
- done pulsed while grant_valid=0 with req=0 → no state change; outputs stay 0.
